cereal_arbiter: RTL and testbench

Shares the single `cereal` serial transmitter between `NREQ` independent byte-stream requesters, for example the message sequencer, a status reporter and a debug echo. Access is granted per message, not per byte: once a requester owns the transmitter, it keeps it until its byte flagged `last` has fully shifted out. Arbitration between messages is round-robin. The block sits between the requesters and `cereal`, driving `cereal`'s `data`/`start` and consuming its `status`.

---
 rtl/cereal_pkg.sv | 18 +
 rtl/cereal_arbiter_rr_picker.sv | 32 +++
 rtl/cereal_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_cereal_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cereal_pkg.sv
// Shared definitions for the cereal serial transmitter and its arbiter.
// Holds the arbiter state encoding and the byte/bit-rate constants that
// the cereal transmitter and every sharer of the serial line agree on.
package cereal_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned BAUD    = 115_200;
  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/cereal_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Searches req_valid upward starting at ptr+1 (modulo NREQ) and returns
// the first set bit as a one-hot pick.
//   req_valid  in   NREQ   candidate requests
//   ptr        in   IDX_W  index of the most recently served requester
//   pick       out  NREQ   one-hot winner, zero when nothing requests
//   any        out  1      at least one request present
module rr_picker
  import cereal_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic             any
);

  // First hit after ptr wins; ptr itself is visited last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!any && req_valid[IDX_W'((32'(ptr) + k) % NREQ)]) begin
        pick[IDX_W'((32'(ptr) + k) % NREQ)] = 1'b1;
        any                                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cereal_arbiter.sv
// cereal_arbiter: shares the single cereal transmitter between NREQ
// byte-stream requesters. Ownership is per message (held until the byte
// flagged last has shifted out); messages are arbitrated round-robin.
// Optional owner-stall timeout: define CEREAL_ARB_TIMEOUT_EN.
//   sysclk     in   1          system clock
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   NREQ       requester i presents a byte
//   req_data   in   8*NREQ     byte of requester i at [8i+:8]
//   req_last   in   NREQ       byte ends requester i's message
//   req_ready  out  NREQ       one-hot acceptance strobe (acceptance cycle)
//   gnt        out  NREQ       one-hot current owner, zero when idle
//   tx_data    out  8          byte to cereal
//   tx_start   out  1          single-cycle start pulse to cereal
//   tx_ready   in   1          cereal idle (1) / shifting (0)
//   abort      out  1          pulse on timeout release, 0 without macro
module cereal_arbiter
  import cereal_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        gnt,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_ready,
  output logic                   abort
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("cereal_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              last_q, last_d;

  logic [NREQ-1:0]   pick;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              sel_valid;
  logic              sel_last;
  logic [BYTE_W-1:0] sel_data;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .pick      (pick),
    .any       (pick_any)
  );

  // One-hot pick to index, kept alongside gnt for muxing.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // Owner's request lines.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef CEREAL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    last_d     = last_q;
    req_ready  = '0;
`ifdef CEREAL_ARB_TIMEOUT_EN
    abort_d    = 1'b0;
    cnt_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick;
          owner_d = pick_idx;
          state_d = SEND;
        end
      end
      SEND: begin
`ifdef CEREAL_ARB_TIMEOUT_EN
        cnt_d = cnt_q;
`endif
        if (sel_valid && tx_ready) begin
          req_ready  = gnt_q;
          tx_data_d  = sel_data;
          tx_start_d = 1'b1;
          last_d     = sel_last;
          state_d    = BUSY;
`ifdef CEREAL_ARB_TIMEOUT_EN
          cnt_d      = '0;
        end else if (!sel_valid) begin
          // Owner stalled: release the line after TIMEOUT_CYC such cycles.
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            abort_d = 1'b1;
            ptr_d   = owner_q;
            gnt_d   = '0;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        if (!tx_ready) state_d = DONE;
      end
      DONE: begin
        if (tx_ready) begin
          if (last_q) begin
            ptr_d   = owner_q;
            gnt_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= IDX_W'(NREQ - 1);
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      last_q     <= 1'b0;
`ifdef CEREAL_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      last_q     <= last_d;
`ifdef CEREAL_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
`ifdef CEREAL_ARB_TIMEOUT_EN
  assign abort    = abort_q;
`else
  assign abort    = 1'b0;
`endif

endmodule

// File: tb/tb_cereal_arbiter.sv
// Bench for cereal_arbiter: requester queues and a cereal busy model drive
// the DUT; transmitted bytes are checked against a round-robin message
// model. Timeout scenario is built when CEREAL_ARB_TIMEOUT_EN is defined.
module tb_cereal_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned TO_CYC = 16;
`ifdef CEREAL_ARB_TIMEOUT_EN
  localparam int EXP_ABORTS = 1;
`else
  localparam int EXP_ABORTS = 0;
`endif

  logic                 sysclk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_last, req_ready, gnt;
  logic [8*NREQ-1:0]    req_data;
  logic [7:0]           tx_data;
  logic                 tx_start, tx_ready, abort;

  cereal_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO_CYC)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .gnt       (gnt),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .abort     (abort)
  );

  always #5 sysclk = ~sysclk;

  int tests = 0;
  int fails = 0;

  byte unsigned q_byte[NREQ][$];
  bit           q_last[NREQ][$];
  byte unsigned m_byte[NREQ][$];
  bit           m_last[NREQ][$];
  int           nbytes[NREQ];
  int           stall[NREQ];
  bit           hold_off[NREQ];
  bit           stall_en = 1'b0;

  int           log_owner[$];
  byte unsigned log_data[$];
  int           log_cyc[$];
  int           exp_owner[$];
  byte unsigned exp_data[$];
  int           ready_cnt[NREQ];
  int           viol = 0;
  int           abort_cnt = 0;
  int           cyc = 0;
  int           cer_busy = 0;
  int           cer_min = 3;
  int           cer_max = 3;

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Environment: monitor at negedge, cereal model and requesters after posedge.
  initial begin
    logic [NREQ-1:0] acc;
    bit st;
    bit l;
    req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    forever begin
      @(negedge sysclk);
      cyc++;
      acc = req_ready;
      st  = tx_start;
      if (tx_start) begin
        log_owner.push_back(oh2idx(gnt));
        log_data.push_back(tx_data);
        log_cyc.push_back(cyc);
        if (!tx_ready) viol++;
      end
      if (abort) abort_cnt++;
      if ($countones(req_ready) > 1 || (req_ready & ~gnt) != '0) viol++;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) ready_cnt[i]++;
      @(posedge sysclk);
      #1;
      if (st) cer_busy = $urandom_range(cer_max, cer_min);
      else if (cer_busy > 0) cer_busy--;
      tx_ready = (cer_busy == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && q_byte[i].size() > 0) begin
          l = q_last[i][0];
          void'(q_byte[i].pop_front());
          void'(q_last[i].pop_front());
          if (!l && stall_en) stall[i] = $urandom_range(3, 0);
        end else if (stall[i] > 0) begin
          stall[i]--;
        end
        req_valid[i]       = (q_byte[i].size() > 0) && (stall[i] == 0) && !hold_off[i];
        req_data[i*8 +: 8] = (q_byte[i].size() > 0) ? q_byte[i][0] : 8'h00;
        req_last[i]        = (q_last[i].size() > 0) ? q_last[i][0] : 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      q_byte[i].delete(); q_last[i].delete();
      m_byte[i].delete(); m_last[i].delete();
      nbytes[i] = 0; stall[i] = 0; ready_cnt[i] = 0; hold_off[i] = 1'b0;
    end
    log_owner.delete(); log_data.delete(); log_cyc.delete();
    viol = 0;
  endtask

  task automatic push_byte(input int r, input byte unsigned b, input bit l);
    q_byte[r].push_back(b); q_last[r].push_back(l);
    m_byte[r].push_back(b); m_last[r].push_back(l);
    nbytes[r]++;
  endtask

  task automatic push_rand_msg(input int r);
    int len;
    len = $urandom_range(4, 1);
    for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
  endtask

  // Whole messages, round-robin over requesters with pending messages.
  task automatic run_model(input int ptr0);
    int p, c;
    bit found, l;
    p = ptr0;
    exp_owner.delete(); exp_data.delete();
    forever begin
      found = 1'b0;
      c = 0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && m_byte[(p + k) % NREQ].size() > 0) begin
          found = 1'b1;
          c = (p + k) % NREQ;
        end
      end
      if (!found) break;
      l = 1'b0;
      while (!l && m_byte[c].size() > 0) begin
        exp_owner.push_back(c);
        exp_data.push_back(m_byte[c].pop_front());
        l = m_last[c].pop_front();
      end
      p = c;
    end
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    int c = 0;
    while (log_owner.size() < n && c < budget) begin
      tick();
      c++;
    end
    ok = (log_owner.size() >= n);
  endtask

  task automatic wait_idle();
    int c = 0;
    bit busy = 1'b1;
    while (busy && c < 2000) begin
      tick();
      c++;
      busy = (gnt != '0) || !tx_ready;
      for (int i = 0; i < NREQ; i++) if (q_byte[i].size() > 0) busy = 1'b1;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL idle_wait: arbiter still busy after %0d cycles, gnt=%b", c, gnt);
    end
    tick();
  endtask

  task automatic compare_log(input string name);
    tests++;
    if (log_owner.size() != exp_owner.size()) begin
      fails++;
      $display("FAIL %s count: got %0d bytes expected %0d", name, log_owner.size(), exp_owner.size());
    end
    for (int k = 0; k < exp_owner.size() && k < log_owner.size(); k++) begin
      tests++;
      if (log_owner[k] !== exp_owner[k] || log_data[k] !== exp_data[k]) begin
        fails++;
        $display("FAIL %s entry %0d: got r%0d/%02h expected r%0d/%02h",
                 name, k, log_owner[k], log_data[k], exp_owner[k], exp_data[k]);
      end
    end
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL %s protocol: got %0d violations expected 0", name, viol);
    end
    for (int i = 0; i < NREQ; i++) begin
      tests++;
      if (ready_cnt[i] !== nbytes[i]) begin
        fails++;
        $display("FAIL %s ready_cnt[%0d]: got %0d expected %0d", name, i, ready_cnt[i], nbytes[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    tests++; if (abort !== 1'b0) begin fails++; $display("FAIL reset_abort: got %b expected 0", abort); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int c;
    byte unsigned exp_b[3];
    exp_b = '{8'h45, 8'h4E, 8'h47};
    clear_all();
    cer_min = 3; cer_max = 3;
    push_byte(0, 8'h45, 1'b0); push_byte(0, 8'h4E, 1'b0); push_byte(0, 8'h47, 1'b1);
    wait_log(3, 300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_wait: got %0d bytes expected 3", log_owner.size()); end
    for (int k = 0; k < 3 && k < log_owner.size(); k++) begin
      tests++;
      if (log_owner[k] !== 0 || log_data[k] !== exp_b[k]) begin
        fails++;
        $display("FAIL single_byte%0d: got r%0d/%02h expected r0/%02h", k, log_owner[k], log_data[k], exp_b[k]);
      end
    end
    c = 0;
    while (tx_ready && c < 50) begin tick(); c++; end
    while (!tx_ready && c < 100) begin tick(); c++; end
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt_held: got %b expected 0001", gnt); end
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL single_gnt_release: got %b expected 0000", gnt); end
    tests++; if (ready_cnt[0] !== 3) begin fails++; $display("FAIL single_ready_cnt: got %0d expected 3", ready_cnt[0]); end
    wait_idle();
  endtask

  task automatic test_round_robin();
    bit ok;
    int rr_ord[6];
    rr_ord = '{0, 1, 2, 3, 0, 1};
    do_reset();
    clear_all();
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < NREQ; i++) push_byte(i, 8'($urandom), 1'b1);
    run_model(NREQ - 1);
    wait_log(12, 2000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rr_wait: got %0d bytes expected 12", log_owner.size()); end
    for (int k = 0; k < 6 && k < log_owner.size(); k++) begin
      tests++;
      if (log_owner[k] !== rr_ord[k]) begin
        fails++;
        $display("FAIL rr_order%0d: got r%0d expected r%0d", k, log_owner[k], rr_ord[k]);
      end
    end
    compare_log("rr");
    wait_idle();
  endtask

  task automatic test_no_preempt();
    bit ok;
    clear_all();
    for (int b = 0; b < 5; b++) push_byte(2, 8'(8'h20 + b), b == 4);
    wait_log(1, 300, ok);
    push_byte(0, 8'h99, 1'b1);
    wait_log(6, 1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL nopre_wait: got %0d bytes expected 6", log_owner.size()); end
    for (int k = 0; k < 5 && k < log_owner.size(); k++) begin
      tests++;
      if (log_owner[k] !== 2 || log_data[k] !== 8'(8'h20 + k)) begin
        fails++;
        $display("FAIL nopre_byte%0d: got r%0d/%02h expected r2/%02h", k, log_owner[k], log_data[k], 8'(8'h20 + k));
      end
    end
    if (log_owner.size() > 5) begin
      tests++;
      if (log_owner[5] !== 0 || log_data[5] !== 8'h99) begin
        fails++;
        $display("FAIL nopre_next: got r%0d/%02h expected r0/99", log_owner[5], log_data[5]);
      end
    end
    tests++; if (viol !== 0) begin fails++; $display("FAIL nopre_protocol: got %0d violations expected 0", viol); end
    wait_idle();
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    clear_all();
    cer_min = 10; cer_max = 10;
    push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h22, 1'b1);
    push_byte(2, 8'h33, 1'b1);
    run_model(NREQ - 1);
    wait_log(3, 500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_wait: got %0d bytes expected 3", log_owner.size()); end
    compare_log("bp");
    if (log_cyc.size() >= 3) begin
      tests++;
      if (log_cyc[1] - log_cyc[0] !== 13) begin
        fails++; $display("FAIL bp_byte_gap: got %0d cycles expected 13", log_cyc[1] - log_cyc[0]);
      end
      tests++;
      if (log_cyc[2] - log_cyc[1] !== 14) begin
        fails++; $display("FAIL bp_msg_gap: got %0d cycles expected 14", log_cyc[2] - log_cyc[1]);
      end
    end
    wait_idle();
  endtask

  task automatic test_random();
    bit ok;
    stall_en = 1'b1;
    cer_min = 1; cer_max = 12;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      clear_all();
      for (int i = 0; i < NREQ; i++)
        for (int m = $urandom_range(3, 0); m > 0; m--) push_rand_msg(i);
      run_model(NREQ - 1);
      wait_log(exp_owner.size(), 4000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL rand_wait: got %0d bytes expected %0d", log_owner.size(), exp_owner.size()); end
      wait_idle();
      compare_log("rand");
    end
    stall_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_all();
    cer_min = 10; cer_max = 10;
    push_byte(1, 8'hC1, 1'b0); push_byte(1, 8'hC2, 1'b0); push_byte(1, 8'hC3, 1'b1);
    wait_log(1, 300, ok);
    tick();
    rst_n = 1'b0;
    #1;
    q_byte[1].delete(); q_last[1].delete();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rstmid_gnt: got %b expected 0000", gnt); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rstmid_tx_start: got %b expected 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rstmid_tx_data: got %h expected 00", tx_data); end
    tick(); tick();
    rst_n = 1'b1;
    log_owner.delete(); log_data.delete(); log_cyc.delete();
    push_byte(3, 8'hD3, 1'b1);
    push_byte(0, 8'hD0, 1'b1);
    wait_log(2, 500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_wait: got %0d bytes expected 2", log_owner.size()); end
    if (log_owner.size() >= 2) begin
      tests++;
      if (log_owner[0] !== 0 || log_data[0] !== 8'hD0 || log_owner[1] !== 3 || log_data[1] !== 8'hD3) begin
        fails++;
        $display("FAIL rstmid_order: got r%0d/%02h r%0d/%02h expected r0/d0 r3/d3",
                 log_owner[0], log_data[0], log_owner[1], log_data[1]);
      end
    end
    wait_idle();
  endtask

`ifdef CEREAL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n, stalled;
    do_reset();
    clear_all();
    cer_min = 3; cer_max = 3;
    push_byte(1, 8'hA1, 1'b0); push_byte(1, 8'hA2, 1'b0); push_byte(1, 8'hA3, 1'b1);
    wait_log(1, 300, ok);
    hold_off[1] = 1'b1;
    push_byte(2, 8'hB0, 1'b1);
    n = 0; stalled = 0;
    while (n < 200) begin
      tick();
      n++;
      if (abort) break;
      if (gnt == 4'b0010 && !req_valid[1] && tx_ready) stalled++;
    end
    tests++; if (abort !== 1'b1) begin fails++; $display("FAIL to_abort: got %b expected 1", abort); end
    tests++;
    if (stalled < TO_CYC || stalled > TO_CYC + 1) begin
      fails++; $display("FAIL to_stall_len: got %0d cycles expected %0d", stalled, TO_CYC);
    end
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL to_release: got %b expected 0000", gnt); end
    tick();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL to_next_gnt: got %b expected 0100", gnt); end
    tests++; if (abort !== 1'b0) begin fails++; $display("FAIL to_abort_pulse: got %b expected 0", abort); end
    wait_log(2, 300, ok);
    tests++;
    if (!ok || log_owner[1] !== 2 || log_data[1] !== 8'hB0) begin
      fails++; $display("FAIL to_next_byte: got %0d bytes expected r2/b0 as byte 2", log_owner.size());
    end
    hold_off[1] = 1'b0;
    q_byte[1].delete(); q_last[1].delete();
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef CEREAL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    tests++;
    if (abort_cnt !== EXP_ABORTS) begin
      fails++; $display("FAIL abort_count: got %0d expected %0d", abort_cnt, EXP_ABORTS);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
